// File: rtl/float_multiplier.sv
// Two-stage pipelined floating-point multiplier (flush-to-zero, round-to-nearest-even).
// Define FLOAT_MULTIPLIER_SPECIALS_EN to decode Inf/NaN operands; otherwise all encodings are finite.
module float_multiplier #(
   parameter int EXP_W   = 8,
   parameter int MAN_W   = 7,
   parameter int FN_MODE = 0
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [EXP_W+MAN_W:0] a,
   input  logic [EXP_W+MAN_W:0] b,
   output logic [EXP_W+MAN_W:0] y
);
   localparam int W    = 1 + EXP_W + MAN_W;
   localparam int PW   = 2*MAN_W + 2;
   localparam int EW   = EXP_W + 2;
   localparam int BIAS = 2**(EXP_W-1) - 1;
   localparam int EMAX = 2**EXP_W - 1;
   localparam logic [EXP_W-1:0] E_ONES = '1;
   localparam logic [MAN_W-1:0] M_ONES = '1;

   logic             sa, sb;
   logic [EXP_W-1:0] ea, eb;
   logic [MAN_W-1:0] ma, mb;
   assign {sa, ea, ma} = a;
   assign {sb, eb, mb} = b;

   logic                 zero_d;
   logic signed [EW-1:0] exp_d;
   logic [PW-1:0]        prod_d;
   assign zero_d = (ea == '0) || (eb == '0);
   assign exp_d  = $signed(EW'({2'b00, ea}) + EW'({2'b00, eb}) - EW'(BIAS));
   assign prod_d = PW'({1'b1, ma}) * PW'({1'b1, mb});

   logic                 s1_sign, s1_zero;
   logic signed [EW-1:0] s1_exp;
   logic [PW-1:0]        s1_prod;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1_sign <= 1'b0;
         s1_zero <= 1'b0;
         s1_exp  <= '0;
         s1_prod <= '0;
      end else begin
         s1_sign <= sa ^ sb;
         s1_zero <= zero_d;
         s1_exp  <= exp_d;
         s1_prod <= prod_d;
      end
   end

`ifdef FLOAT_MULTIPLIER_SPECIALS_EN
   localparam logic [W-1:0] NAN_VAL = (FN_MODE == 0) ?
      {1'b0, E_ONES, 1'b1, {(MAN_W-1){1'b0}}} : {1'b0, E_ONES, M_ONES};

   logic nan_d, inf_d, s1_nan, s1_inf;
   generate
      if (FN_MODE == 0) begin : g_dec_ieee
         assign nan_d = (ea == E_ONES && ma != '0) || (eb == E_ONES && mb != '0);
         assign inf_d = (ea == E_ONES && ma == '0) || (eb == E_ONES && mb == '0);
      end else begin : g_dec_fn
         assign nan_d = ({ea, ma} == {E_ONES, M_ONES}) || ({eb, mb} == {E_ONES, M_ONES});
         assign inf_d = 1'b0;
      end
   endgenerate

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1_nan <= 1'b0;
         s1_inf <= 1'b0;
      end else begin
         s1_nan <= nan_d;
         s1_inf <= inf_d;
      end
   end
`endif

   logic                 norm, guard, sticky, round_up, carry, under, over;
   logic [MAN_W-1:0]     kept, man_r;
   logic signed [EW-1:0] exp_f;
   logic [EW-1:0]        exp_u;
   logic [W-1:0]         max_fin, y_d;

   always_comb begin
      norm = s1_prod[PW-1];
      // Product is in [1,4); pick the MAN_W bits below the leading one.
      if (norm) begin
         kept   = s1_prod[PW-2 -: MAN_W];
         guard  = s1_prod[MAN_W];
         sticky = |s1_prod[MAN_W-1:0];
      end else begin
         kept   = s1_prod[PW-3 -: MAN_W];
         guard  = s1_prod[MAN_W-1];
         sticky = |s1_prod[MAN_W-2:0];
      end
      round_up       = guard & (sticky | kept[0]);
      {carry, man_r} = {1'b0, kept} + {{MAN_W{1'b0}}, round_up};
      exp_f = s1_exp + $signed({{(EW-1){1'b0}}, norm}) + $signed({{(EW-1){1'b0}}, carry});
      exp_u = exp_f;
      under = exp_f[EW-1] || (exp_f == '0);
      // In FN mode the all-ones exponent is still finite except for the NaN mantissa.
      if (FN_MODE == 0)
         over = !exp_f[EW-1] && (exp_u >= EW'(EMAX));
      else
         over = !exp_f[EW-1] && ((exp_u > EW'(EMAX)) || (exp_u == EW'(EMAX) && man_r == M_ONES));
      max_fin = (FN_MODE == 0) ? {s1_sign, E_ONES - 1'b1, M_ONES}
                               : {s1_sign, E_ONES, M_ONES - 1'b1};

      y_d = {s1_sign, exp_u[EXP_W-1:0], man_r};
      if (s1_zero || under)
         y_d = {s1_sign, {(W-1){1'b0}}};
      else if (over)
`ifdef FLOAT_MULTIPLIER_SPECIALS_EN
         y_d = (FN_MODE == 0) ? {s1_sign, E_ONES, {MAN_W{1'b0}}} : max_fin;
      if (s1_nan || (s1_inf && s1_zero))
         y_d = NAN_VAL;
      else if (s1_inf)
         y_d = {s1_sign, E_ONES, {MAN_W{1'b0}}};
`else
         y_d = max_fin;
`endif
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) y <= '0;
      else       y <= y_d;
   end
endmodule

// File: tb/tb_float_multiplier.sv
// Bench for float_multiplier: bf16 and E4M3 instances, directed table, random stream
// against an arithmetic reference model, and mid-stream reset.
module tb_float_multiplier;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] a_bf, b_bf, y_bf;
  logic [7:0]  a_e4, b_e4, y_e4;
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  float_multiplier #(.EXP_W(8), .MAN_W(7), .FN_MODE(0)) u_bf (
    .clock(clock), .reset(reset), .a(a_bf), .b(b_bf), .y(y_bf));
  float_multiplier #(.EXP_W(4), .MAN_W(3), .FN_MODE(1)) u_e4 (
    .clock(clock), .reset(reset), .a(a_e4), .b(b_e4), .y(y_e4));

  typedef struct {
    bit          e4;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] y;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] q_bf[$];
  logic [15:0] q_e4[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  // Exact integer product, then RNE by comparing the remainder with one half.
  function automatic int fmul_ref(input int a, input int b, input int ew, input int mw, input bit fn);
    int bias, emax, sa, sb, ea, eb, ma, mb, sbit, p, sh, q, rem, half, e, m, mask;
    bit ovf;
    bias = (1 << (ew-1)) - 1;
    emax = (1 << ew) - 1;
    mask = (1 << (ew+mw)) - 1;
    sa = (a >> (ew+mw)) & 1;  sb = (b >> (ew+mw)) & 1;
    ea = (a >> mw) & emax;    eb = (b >> mw) & emax;
    ma = a & ((1 << mw) - 1); mb = b & ((1 << mw) - 1);
    sbit = (sa ^ sb) << (ew+mw);
`ifdef FLOAT_MULTIPLIER_SPECIALS_EN
    if (fn) begin
      if ((a & mask) == mask || (b & mask) == mask) return (emax << mw) | ((1 << mw) - 1);
    end else begin
      if ((ea == emax && ma != 0) || (eb == emax && mb != 0)) return (emax << mw) | (1 << (mw-1));
      if (ea == emax || eb == emax)
        return (ea == 0 || eb == 0) ? ((emax << mw) | (1 << (mw-1))) : (sbit | (emax << mw));
    end
`endif
    if (ea == 0 || eb == 0) return sbit;
    p  = ((1 << mw) + ma) * ((1 << mw) + mb);
    sh = (p >= (1 << (2*mw+1))) ? mw + 1 : mw;
    q  = p >> sh;
    rem  = p - (q << sh);
    half = 1 << (sh-1);
    if (rem > half || (rem == half && (q % 2) == 1)) q++;
    if (q == (1 << (mw+1))) begin q = q / 2; sh++; end
    e = ea + eb - bias + (sh - mw);
    m = q - (1 << mw);
    if (e <= 0) return sbit;
`ifdef FLOAT_MULTIPLIER_SPECIALS_EN
    if (!fn && e >= emax) return sbit | (emax << mw);
`endif
    ovf = fn ? (e > emax || (e == emax && m == (1 << mw) - 1)) : (e >= emax);
    if (ovf)
      return fn ? (sbit | (emax << mw) | ((1 << mw) - 2)) : (sbit | ((emax-1) << mw) | ((1 << mw) - 1));
    return sbit | (e << mw) | m;
  endfunction

  function automatic logic [15:0] rnd_bf(input int i);
    logic [15:0] v;
    v = 16'($urandom);
    if (i % 2 == 1) v[14:7] = 8'(117 + $urandom_range(0, 20));
    return v;
  endfunction

  function automatic logic [7:0] rnd_e4(input int i);
    logic [7:0] v;
    v = 8'($urandom);
    if (i % 2 == 1) v[6:3] = 4'(4 + $urandom_range(0, 6));
    return v;
  endfunction

  initial begin
    logic [15:0] act, ra, rb;
    logic [7:0]  ea8, eb8;
    a_bf = '0; b_bf = '0; a_e4 = '0; b_e4 = '0;

    vecs.push_back('{1'b1, 16'h0040, 16'h0040, 16'h0048});
    vecs.push_back('{1'b1, 16'h0038, 16'h00B8, 16'h00B8});
    vecs.push_back('{1'b1, 16'h0040, 16'h0039, 16'h0041});
    vecs.push_back('{1'b1, 16'h00AC, 16'h00C0, 16'h0034});
    vecs.push_back('{1'b1, 16'h0000, 16'h0000, 16'h0000});
    vecs.push_back('{1'b1, 16'h007E, 16'h0040, 16'h007E});
    vecs.push_back('{1'b0, 16'h3F80, 16'hBF80, 16'hBF80});
    vecs.push_back('{1'b0, 16'hBF80, 16'hBF80, 16'h3F80});
    vecs.push_back('{1'b0, 16'hBF40, 16'h3FE0, 16'hBFA8});
    vecs.push_back('{1'b0, 16'h0000, 16'h0000, 16'h0000});
    vecs.push_back('{1'b0, 16'h4348, 16'h3A83, 16'h3E4D});
    vecs.push_back('{1'b0, 16'h3FFF, 16'h3FE0, 16'h405F});
    vecs.push_back('{1'b0, 16'h0080, 16'h3F00, 16'h0000});
`ifdef FLOAT_MULTIPLIER_SPECIALS_EN
    vecs.push_back('{1'b0, 16'h7F00, 16'h4000, 16'h7F80});
    vecs.push_back('{1'b0, 16'h7F80, 16'h0000, 16'h7FC0});
    vecs.push_back('{1'b0, 16'h7F80, 16'hBF80, 16'hFF80});
    vecs.push_back('{1'b1, 16'h007F, 16'h0038, 16'h007F});
`else
    vecs.push_back('{1'b0, 16'h7F00, 16'h4000, 16'h7F7F});
`endif

    #2;
    chk("reset_bf", y_bf, 16'h0000);
    chk("reset_e4", {8'h00, y_e4}, 16'h0000);
    @(negedge clock) reset = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clock);
      if (vecs[i].e4) begin
        a_e4 = vecs[i].a[7:0]; b_e4 = vecs[i].b[7:0];
      end else begin
        a_bf = vecs[i].a; b_bf = vecs[i].b;
      end
      repeat (2) @(posedge clock);
      #1;
      act = vecs[i].e4 ? {8'h00, y_e4} : y_bf;
      chk($sformatf("vec%0d_%h_x_%h", i, vecs[i].a, vecs[i].b), act, vecs[i].y);
    end

    // Back-to-back random operands; each result is due exactly two edges later.
    for (int i = 0; i < 402; i++) begin
      @(negedge clock);
      if (i >= 2) begin
        chk($sformatf("stream_bf%0d", i), y_bf, q_bf.pop_front());
        chk($sformatf("stream_e4%0d", i), {8'h00, y_e4}, q_e4.pop_front());
      end
      if (i < 400) begin
        ra = rnd_bf(i); rb = rnd_bf(i + 1);
        ea8 = rnd_e4(i); eb8 = rnd_e4(i + 1);
        a_bf = ra; b_bf = rb; a_e4 = ea8; b_e4 = eb8;
        q_bf.push_back(16'(fmul_ref(int'(ra), int'(rb), 8, 7, 1'b0)));
        q_e4.push_back(16'(fmul_ref(int'(ea8), int'(eb8), 4, 3, 1'b1)));
      end
    end

    @(negedge clock);
    a_bf = 16'h3F80; b_bf = 16'h3F80; a_e4 = 8'h40; b_e4 = 8'h40;
    repeat (2) @(posedge clock);
    #1;
    chk("pre_rst_bf", y_bf, 16'h3F80);
    chk("pre_rst_e4", {8'h00, y_e4}, 16'h0048);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_bf", y_bf, 16'h0000);
    chk("rst_async_e4", {8'h00, y_e4}, 16'h0000);
    @(posedge clock);
    @(negedge clock) reset = 1'b0;
    @(posedge clock);
    #1;
    chk("rst_edge1_bf", y_bf, 16'h0000);
    chk("rst_edge1_e4", {8'h00, y_e4}, 16'h0000);
    @(posedge clock);
    #1;
    chk("rst_edge2_bf", y_bf, 16'h3F80);
    chk("rst_edge2_e4", {8'h00, y_e4}, 16'h0048);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
